// File: rtl/move_command_arbiter.sv
// move_command_arbiter: turns four debounced direction buttons into single
// 2048 move commands. Press edges are detected, simultaneous presses resolved
// by fixed priority (UP > DOWN > LEFT > RIGHT), one command at a time is
// offered over valid/ready, and a holdoff window follows each accepted move.
// Optional feature: define AUTOREPEAT_EN to re-issue the last direction while
// its button stays held.
module move_command_arbiter #(
    parameter int HOLDOFF_CYCLES = 4,
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 5_000_000,
    parameter int CNT_W          = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       game_over,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       busy,
    output logic [7:0] dropped_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

    state_t           state, state_nxt;
    logic [3:0]       btn_vec;    // bit index equals the direction code
    logic [3:0]       prev_vec;
    logic [3:0]       edge_vec;
    logic             win_valid;
    logic [1:0]       win_dir;
    logic             multi_edge;
    logic             handshake;
    logic             load_dir;
    logic [1:0]       dir_nxt;
    logic [1:0]       dir_q;
    logic [CNT_W-1:0] hold_timer;
    logic             drop_evt;

    assign btn_vec    = {btn_right, btn_left, btn_down, btn_up};
    assign edge_vec   = btn_vec & ~prev_vec;
    assign multi_edge = (edge_vec & (edge_vec - 4'd1)) != 4'd0;
    assign handshake  = (state == ISSUE) && move_ready;

    // Fixed-priority pick of the winning press edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_valid = 1'b1;
        win_dir   = 2'b00;
        if      (edge_vec[0]) win_dir = 2'b00;
        else if (edge_vec[1]) win_dir = 2'b01;
        else if (edge_vec[2]) win_dir = 2'b10;
        else if (edge_vec[3]) win_dir = 2'b11;
        else                  win_valid = 1'b0;
    end

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LOAD =
        (REPEAT_DELAY > 0) ? CNT_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] PER_LOAD =
        (REPEAT_PERIOD > 0) ? CNT_W'(REPEAT_PERIOD - 1) : '0;

    logic             rep_armed;
    logic             rep_first;
    logic [1:0]       rep_dir;
    logic [CNT_W-1:0] rep_timer;
    logic             rep_fire;
    logic             new_win;

    assign new_win  = (state == IDLE) && win_valid && !game_over;
    assign rep_fire = rep_armed && btn_vec[rep_dir] && (rep_timer == '0) && !game_over;

    // Track the held direction and time the next repeat from each handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_armed <= 1'b0;
            rep_first <= 1'b0;
            rep_dir   <= 2'b00;
            rep_timer <= '0;
        end else begin
            if (new_win) begin
                rep_armed <= 1'b1;
                rep_first <= 1'b1;
                rep_dir   <= win_dir;
            end else if (!btn_vec[rep_dir]) begin
                rep_armed <= 1'b0;
            end
            if (handshake) begin
                rep_timer <= rep_first ? DLY_LOAD : PER_LOAD;
                rep_first <= 1'b0;
            end else if (rep_timer != '0) begin
                rep_timer <= rep_timer - CNT_W'(1);
            end
        end
    end
`else
    logic rep_fire;
    logic [1:0] rep_dir;
    logic unused_repeat_cfg;
    assign rep_fire = 1'b0;
    assign rep_dir  = 2'b00;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; also decides when move_dir is captured.
    always_comb begin
        state_nxt = state;
        load_dir  = 1'b0;
        dir_nxt   = win_dir;
        case (state)
            IDLE: begin
                if (win_valid && !game_over) begin
                    state_nxt = ISSUE;
                    load_dir  = 1'b1;
                end else if (rep_fire) begin
                    state_nxt = ISSUE;
                    load_dir  = 1'b1;
                    dir_nxt   = rep_dir;
                end
            end
            ISSUE: begin
                if (handshake) state_nxt = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_timer == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        move_valid = (state == ISSUE);
        busy       = (state != IDLE);
        move_dir   = dir_q;
    end

    // A press is discarded if it loses priority in IDLE or arrives while busy.
    assign drop_evt = !game_over &&
                      (((state == IDLE) && multi_edge) || ((state != IDLE) && (edge_vec != 4'd0)));

    // Datapath: button history, latched direction, holdoff timer, drop counter.
    always_ff @(posedge clk) begin
        // Buttons held through reset are absorbed into the history and never fire.
        prev_vec <= btn_vec;
        if (reset) begin
            dir_q       <= 2'b00;
            hold_timer  <= '0;
            dropped_cnt <= 8'd0;
        end else begin
            if (load_dir) dir_q <= dir_nxt;
            if (handshake)
                hold_timer <= HOLD_LOAD;
            else if ((state == HOLDOFF) && (hold_timer != '0))
                hold_timer <= hold_timer - CNT_W'(1);
            if (drop_evt && (dropped_cnt != 8'hFF))
                dropped_cnt <= dropped_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_move_command_arbiter.sv
// Testbench for move_command_arbiter (default build, HOLDOFF_CYCLES = 4).
// Table-driven cycle vectors plus hand-written sequences for reset and
// counter saturation.
module tb_move_command_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b1, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       game_over = 1'b0;
    logic       move_ready = 1'b1;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       busy;
    logic [7:0] dropped_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    move_command_arbiter #(.HOLDOFF_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .game_over(game_over), .move_ready(move_ready),
        .move_valid(move_valid), .move_dir(move_dir), .busy(busy), .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;

    // One vector = inputs for a cycle and the outputs expected after its rising edge.
    // btn bits are {up, down, left, right}; dir is checked only when valid is expected.
    typedef struct {
        logic [3:0] btn;
        logic       go;
        logic       rdy;
        logic       ev;
        logic [1:0] ed;
        logic       eb;
        logic [7:0] edrop;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic [3:0] b, logic go, logic rdy,
                               logic ev, logic [1:0] ed, logic eb, logic [7:0] dr);
        vec_t r;
        r.btn = b; r.go = go; r.rdy = rdy; r.ev = ev; r.ed = ed; r.eb = eb; r.edrop = dr;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive inputs just after a rising edge, then advance one edge and settle.
    task automatic step(input logic [3:0] b, input logic go, input logic rdy, input logic rst);
        btn_up = b[3]; btn_down = b[2]; btn_left = b[1]; btn_right = b[0];
        game_over = go; move_ready = rdy; reset = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 2: single LEFT press, ready high, 1 ISSUE + 4 HOLDOFF cycles busy
        vq.push_back(v(4'b0010, 0, 1, 1, 2'b10, 1, 0));
        vq.push_back(v(4'b0010, 0, 1, 0, 2'b00, 1, 0));
        vq.push_back(v(4'b0010, 0, 1, 0, 2'b00, 1, 0));
        vq.push_back(v(4'b0010, 0, 1, 0, 2'b00, 1, 0));
        vq.push_back(v(4'b0010, 0, 1, 0, 2'b00, 1, 0));
        vq.push_back(v(4'b0010, 0, 1, 0, 2'b00, 0, 0));
        vq.push_back(v(4'b0000, 0, 1, 0, 2'b00, 0, 0));
        // Test 3: UP and RIGHT together -> UP wins, one drop
        vq.push_back(v(4'b1001, 0, 1, 1, 2'b00, 1, 1));
        vq.push_back(v(4'b1001, 0, 1, 0, 2'b00, 1, 1));
        vq.push_back(v(4'b1001, 0, 1, 0, 2'b00, 1, 1));
        vq.push_back(v(4'b1001, 0, 1, 0, 2'b00, 1, 1));
        vq.push_back(v(4'b1001, 0, 1, 0, 2'b00, 1, 1));
        vq.push_back(v(4'b1001, 0, 1, 0, 2'b00, 0, 1));
        vq.push_back(v(4'b0000, 0, 1, 0, 2'b00, 0, 1));
        // Test 4: RIGHT held off by ready low for 5 cycles, DOWN pressed meanwhile
        vq.push_back(v(4'b0001, 0, 0, 1, 2'b11, 1, 1));
        vq.push_back(v(4'b0001, 0, 0, 1, 2'b11, 1, 1));
        vq.push_back(v(4'b0101, 0, 0, 1, 2'b11, 1, 2));
        vq.push_back(v(4'b0101, 0, 0, 1, 2'b11, 1, 2));
        vq.push_back(v(4'b0101, 0, 0, 1, 2'b11, 1, 2));
        vq.push_back(v(4'b0101, 0, 1, 0, 2'b00, 1, 2));
        vq.push_back(v(4'b0101, 0, 1, 0, 2'b00, 1, 2));
        vq.push_back(v(4'b0101, 0, 1, 0, 2'b00, 1, 2));
        vq.push_back(v(4'b0101, 0, 1, 0, 2'b00, 1, 2));
        vq.push_back(v(4'b0101, 0, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0000, 0, 1, 0, 2'b00, 0, 2));
        // Test 5: game_over ignores presses and does not count them
        vq.push_back(v(4'b1000, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0000, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0100, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0000, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0010, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0000, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0001, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0000, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b1111, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0000, 1, 1, 0, 2'b00, 0, 2));
        vq.push_back(v(4'b0000, 0, 1, 0, 2'b00, 0, 2));
        // game_over rising in ISSUE does not withdraw; press during HOLDOFF is dropped
        vq.push_back(v(4'b0100, 0, 0, 1, 2'b01, 1, 2));
        vq.push_back(v(4'b0100, 1, 0, 1, 2'b01, 1, 2));
        vq.push_back(v(4'b0100, 1, 1, 0, 2'b00, 1, 2));
        vq.push_back(v(4'b0110, 0, 1, 0, 2'b00, 1, 3));
        vq.push_back(v(4'b0110, 0, 1, 0, 2'b00, 1, 3));
        vq.push_back(v(4'b0110, 0, 1, 0, 2'b00, 1, 3));
        vq.push_back(v(4'b0110, 0, 1, 0, 2'b00, 0, 3));
        vq.push_back(v(4'b0000, 0, 1, 0, 2'b00, 0, 3));

        // Test 1: UP held through reset and for 20 cycles afterwards never fires
        for (int i = 0; i < 3; i++) step(4'b1000, 0, 1, 1);
        check("reset.valid", 8'(move_valid), 8'd0);
        check("reset.dir",   8'(move_dir),   8'd0);
        check("reset.busy",  8'(busy),       8'd0);
        check("reset.drop",  dropped_cnt,    8'd0);
        for (int i = 0; i < 20; i++) begin
            step(4'b1000, 0, 1, 0);
            check($sformatf("held%0d.valid", i), 8'(move_valid), 8'd0);
            check($sformatf("held%0d.drop", i),  dropped_cnt,    8'd0);
        end
        step(4'b0000, 0, 1, 0);

        // Table-driven vectors
        foreach (vq[i]) begin
            step(vq[i].btn, vq[i].go, vq[i].rdy, 1'b0);
            check($sformatf("v%0d.valid", i), 8'(move_valid), 8'(vq[i].ev));
            if (vq[i].ev) check($sformatf("v%0d.dir", i), 8'(move_dir), 8'(vq[i].ed));
            check($sformatf("v%0d.busy", i), 8'(busy), 8'(vq[i].eb));
            check($sformatf("v%0d.drop", i), dropped_cnt, vq[i].edrop);
        end

        // Saturation: park in ISSUE, toggle DOWN 260 times (3 + 260 > 255)
        step(4'b1000, 0, 0, 0);
        check("sat.start.valid", 8'(move_valid), 8'd1);
        for (int i = 0; i < 260; i++) begin
            step(4'b1100, 0, 0, 0);
            step(4'b1000, 0, 0, 0);
        end
        check("sat.drop",  dropped_cnt,    8'd255);
        check("sat.valid", 8'(move_valid), 8'd1);
        check("sat.dir",   8'(move_dir),   8'd0);
        step(4'b1100, 0, 0, 0);
        check("sat.hold",  dropped_cnt,    8'd255);

        // Reset mid-operation clears everything; held UP does not fire afterwards
        step(4'b1000, 0, 0, 1);
        check("midrst.valid", 8'(move_valid), 8'd0);
        check("midrst.busy",  8'(busy),       8'd0);
        check("midrst.dir",   8'(move_dir),   8'd0);
        check("midrst.drop",  dropped_cnt,    8'd0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1000, 0, 1, 0);
            check($sformatf("post%0d.valid", i), 8'(move_valid), 8'd0);
        end
        step(4'b0000, 0, 1, 0);
        step(4'b0010, 0, 1, 0);
        check("post.press.valid", 8'(move_valid), 8'd1);
        check("post.press.dir",   8'(move_dir),   8'd2);
        step(4'b0010, 0, 1, 0);
        check("post.press.once",  8'(move_valid), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
